// File: rtl/msrv32_fetch_decode_stage_if.sv
// Fetch/decode handshake bundle for msrv32_fetch_decode_stage.
// slave is the stage itself; master is the fetch unit plus decode consumer.
interface msrv32_fetch_decode_stage_if;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic        flush_in;
  logic        dec_ready_in;
  logic        valid_out;
  logic [24:0] instr_out;
  logic [6:0]  opcode_out;
  logic [2:0]  imm_type_out;
  logic [31:0] pc_out;
  logic        illegal_out;

  modport slave (
    input  instr_in, pc_in, instr_valid_in, flush_in, dec_ready_in,
    output instr_ready_out, valid_out, instr_out, opcode_out,
           imm_type_out, pc_out, illegal_out
  );

  modport master (
    output instr_in, pc_in, instr_valid_in, flush_in, dec_ready_in,
    input  instr_ready_out, valid_out, instr_out, opcode_out,
           imm_type_out, pc_out, illegal_out
  );
endinterface

// File: rtl/msrv32_fetch_decode_stage.sv
// Fetch-to-decode skid FIFO (2 entries) with push-time immediate-type decode.
// Outputs are driven only from registered state; an empty stage presents a NOP.
module msrv32_fetch_decode_stage #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                           ms_riscv32_mp_clk_in,
  input  logic                           ms_riscv32_mp_rst_in,
  msrv32_fetch_decode_stage_if.slave     bus
);

  logic [31:0] instr_q [DEPTH];
  logic [31:0] instr_d [DEPTH];
  logic [31:0] pc_q    [DEPTH];
  logic [31:0] pc_d    [DEPTH];
  logic [2:0]  type_q  [DEPTH];
  logic [2:0]  type_d  [DEPTH];
  logic        ill_q   [DEPTH];
  logic        ill_d   [DEPTH];

  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] last_pc_q, last_pc_d;

  logic        push, pop;
  logic [2:0]  dec_type;
  logic        dec_ill;

  assign bus.valid_out       = (count_q != 2'd0);
  assign bus.instr_ready_out = (count_q != 2'd2);

  assign push = bus.instr_valid_in & bus.instr_ready_out & ~bus.flush_in;
  assign pop  = bus.valid_out & bus.dec_ready_in & ~bus.flush_in;

  always_comb begin
    dec_type = 3'b000;
    dec_ill  = 1'b0;
    case (bus.instr_in[6:0])
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b0110011, 7'b0001111: dec_type = 3'b000;
      7'b0100011:             dec_type = 3'b001;
      7'b1100011:             dec_type = 3'b010;
      7'b0110111, 7'b0010111: dec_type = 3'b011;
      7'b1101111:             dec_type = 3'b100;
      // ECALL/EBREAK (funct3 = 0) carry no CSR immediate
      7'b1110011:             dec_type = (bus.instr_in[14:12] != 3'b000) ? 3'b101 : 3'b000;
      default:                dec_ill  = 1'b1;
    endcase
  end

  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    type_d    = type_q;
    ill_d     = ill_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;

    if (bus.flush_in) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = bus.instr_in;
        pc_d[wr_ptr_q]    = bus.pc_in;
        type_d[wr_ptr_q]  = dec_type;
        ill_d[wr_ptr_q]   = dec_ill;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        last_pc_d = pc_q[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + 1'b1;
      end
      if (push && !pop)
        count_d = count_q + 2'd1;
      else if (pop && !push)
        count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        type_q[i]  <= '0;
        ill_q[i]   <= 1'b0;
      end
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      last_pc_q <= RESET_PC;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      type_q    <= type_d;
      ill_q     <= ill_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  always_comb begin
    bus.instr_out    = 25'h0;
    bus.opcode_out   = 7'b0010011;
    bus.imm_type_out = 3'b000;
    bus.illegal_out  = 1'b0;
    bus.pc_out       = last_pc_q;
    if (bus.valid_out) begin
      bus.instr_out    = instr_q[rd_ptr_q][31:7];
      bus.opcode_out   = instr_q[rd_ptr_q][6:0];
      bus.imm_type_out = type_q[rd_ptr_q];
      bus.illegal_out  = ill_q[rd_ptr_q];
      bus.pc_out       = pc_q[rd_ptr_q];
    end
  end

endmodule

// File: doc/msrv32_fetch_decode_stage.md
# msrv32_fetch_decode_stage

Fetch-to-decode pipeline stage of the MSRV32 core, directly upstream of `msrv32_imm_generator`. It accepts fetched instruction words with their PC under a valid/ready handshake and buffers them in a 2-entry skid FIFO. For the head entry it presents `instr[31:7]` plus a decoded 3-bit immediate-type code in the encoding the immediate generator consumes. A flush input discards all buffered instructions on a taken branch or trap.

## Interface
Parameters:
- `DEPTH`, 2, FIFO entries; fixed at 2, no other value supported.
- `RESET_PC`, 32'h0000_0000, value of `pc_out` while empty after reset.

Ports:
- `ms_riscv32_mp_clk_in`  in  1  clock; all state updates on rising edge.
- `ms_riscv32_mp_rst_in`  in  1  reset, asynchronous, active-high.
- `instr_in`  in  32  fetched instruction word.
- `pc_in`  in  32  PC of `instr_in`.
- `instr_valid_in`  in  1  fetch presents a word.
- `instr_ready_out`  out  1  stage can accept; a transfer occurs when valid and ready are both high.
- `flush_in`  in  1  discard all buffered entries this cycle.
- `dec_ready_in`  in  1  decode/execute consumes the head entry.
- `valid_out`  out  1  head entry is valid.
- `instr_out`  out  25  `instr[31:7]` of the head entry; drives the `instr_in` port of the immediate generator.
- `opcode_out`  out  7  `instr[6:0]` of the head entry.
- `imm_type_out`  out  3  immediate type of the head entry.
- `pc_out`  out  32  PC of the head entry.
- `illegal_out`  out  1  head opcode is not RV32I; qualified by `valid_out`.

## Operation
- Storage: 2 entries, each holding instr[31:0], pc, imm_type[2:0] and illegal. `imm_type` and `illegal` are decoded at push time and stored with the entry, not decoded at the output.
- Pointers: 1-bit read pointer, 1-bit write pointer, 2-bit count (0..2). Both pointers wrap 1→0.
- Conditions:
  - push = `instr_valid_in & instr_ready_out & ~flush_in`
  - pop = `valid_out & dec_ready_in & ~flush_in`
- `instr_ready_out` = (count != 2). It is combinational from registered count and does not depend on `dec_ready_in`.
- `valid_out` = (count != 0).
- imm_type decode, keyed on `instr[6:0]`:
  - 0000011, 0010011, 1100111 → 000 (I)
  - 0100011 → 001 (S)
  - 1100011 → 010 (B)
  - 0110111, 0010111 → 011 (U)
  - 1101111 → 100 (J)
  - 1110011 with funct3 != 000 → 101 (CSR); with funct3 = 000 → 000
  - 0110011, 0001111 → 000
  - any other opcode → 000 with illegal = 1
- Empty output: `instr_out` = 25'h0, `opcode_out` = 7'b0010011, `imm_type_out` = 000, `pc_out` = last popped PC (`RESET_PC` after reset), `illegal_out` = 0. While empty, instr/opcode together form the NOP 0x00000013.
- Count update:
  - push & ~pop → count+1
  - pop & ~push → count−1
  - push & pop → count unchanged, both pointers advance
- Flush: count, read pointer and write pointer go to 0 at the next edge. Any simultaneous `instr_valid_in` is dropped and any pop is cancelled. Entry data is not cleared.

## Timing
- Reset (async): count = 0, both pointers = 0, stored PC = `RESET_PC`. Outputs take their empty values immediately: `valid_out` = 0, `instr_ready_out` = 1.
- Latency: a word accepted at edge N appears on the outputs after edge N (visible in cycle N+1) when the FIFO was empty. There is no combinational path from input to output.
- Throughput: one instruction per cycle while `dec_ready_in` is held high.
- Full (count = 2): `instr_ready_out` = 0 and no push occurs. A pop at count 2 raises ready in the following cycle, not the same one.
- Empty with `dec_ready_in` = 1: no pop and no underflow; count stays 0.
- Output stability: head-entry outputs hold while `valid_out` = 1 and `dec_ready_in` = 0.
- Reset asserted mid-stream: all entries are lost immediately, with no partial pop.

## Test plan
- Reset: assert `ms_riscv32_mp_rst_in` asynchronously between edges → in the same cycle `valid_out` = 0, `instr_ready_out` = 1, `instr_out` = 0, `opcode_out` = 7'h13, `pc_out` = `RESET_PC`.
- Type decode: push 0x00A00093, 0x00112023, 0x00208463, 0x123450B7, 0x0080006F, 0x30002373 with `dec_ready_in` = 1 → `imm_type_out` = 000, 001, 010, 011, 100, 101 respectively, each one cycle after its push. For 0x00A00093, `instr_out` = 0x00A00093>>7.
- Backpressure: `dec_ready_in` = 0, push PC 0x0, 0x4, 0x8 → `instr_ready_out` drops after the second push and the third word is held by fetch. Then `dec_ready_in` = 1 → PCs 0x0, 0x4, 0x8 pop in order with none lost or duplicated.
- Simultaneous push and pop at count 1: count stays 1 and `pc_out` advances by exactly one entry per cycle.
- Flush: with 2 entries buffered, assert `flush_in` together with `instr_valid_in` = 1 → next cycle `valid_out` = 0 and the concurrent word is not stored.
- Illegal opcode: push 0x0000007F → `illegal_out` = 1 and `imm_type_out` = 000 while that entry is at the head.
